// File: rtl/audio_pkg.sv
// Shared definitions for the piano_note audio path: melody entry layout,
// note constants and the sequencer state encoding.
package audio_pkg;

   localparam logic [3:0] NOTE_REST     = 4'hF;
   localparam logic [3:0] NUM_SEMITONES = 4'd12;

   localparam int ENTRY_W  = 11;
   localparam int NOTE_LSB = 7;
   localparam int NOTE_W   = 4;
   localparam int OCT_LSB  = 4;
   localparam int OCT_W    = 3;
   localparam int DUR_LSB  = 0;
   localparam int DUR_W    = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SOUND = 3'd2,
      S_GAP   = 3'd3,
      S_REST  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/seq_mem.sv
// Melody storage: DEPTH entries, synchronous write, combinational read.
// A read in the same cycle as a write to that address returns the old data.
module seq_mem
   import audio_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Melody player feeding the piano_note tone generator: walks the stored
// entries with beat-accurate timing and a release gap after each sounding note.
module note_sequencer
   import audio_pkg::*;
#(
   parameter int CLK_PER_BEAT = 25000000,
   parameter int GAP_CLKS     = 1000000,
   parameter int DEPTH        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [ENTRY_W-1:0]       wr_data,
   input  logic [$clog2(DEPTH):0]   seq_len,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     loop_en,
   output logic                     key_press,
   output logic [NOTE_W-1:0]        note_idx,
   output logic [OCT_W-1:0]         octave,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] cur_step
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(15 * CLK_PER_BEAT + 1);

   seq_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]      step_q, step_d;
   logic [NOTE_W-1:0]  note_q, note_d;
   logic [OCT_W-1:0]   oct_q, oct_d;
   logic               done_q, done_d;

   logic [AW-1:0]      rd_addr;
   logic [ENTRY_W-1:0] rd_data;
   logic [NOTE_W-1:0]  rd_note;
   logic [OCT_W-1:0]   rd_oct;
   logic [DUR_W-1:0]   rd_dur;
   logic [DUR_W-1:0]   dur_eff;
   logic [CNT_W-1:0]   step_len;
   logic [AW:0]        len_eff;
   logic               last_step;
   logic               step_end;
   logic               load;

   seq_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign rd_note = rd_data[NOTE_LSB +: NOTE_W];
   assign rd_oct  = rd_data[OCT_LSB +: OCT_W];
   assign rd_dur  = rd_data[DUR_LSB +: DUR_W];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      step_d    = step_q;
      note_d    = note_q;
      oct_d     = oct_q;
      done_d    = 1'b0;
      rd_addr   = '0;
      load      = 1'b0;
      step_end  = 1'b0;
      dur_eff   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
      step_len  = CNT_W'(dur_eff) * CNT_W'(CLK_PER_BEAT);
      len_eff   = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;
      last_step = (({1'b0, step_q} + (AW+1)'(1)) >= len_eff);

      case (state_q)
         S_IDLE: begin
            if (start && !stop && (len_eff != '0)) begin
               load   = 1'b1;
               step_d = '0;
            end
         end
         S_SOUND: begin
            if (cnt_q == '0) begin
               if (GAP_CLKS == 0) begin
                  step_end = 1'b1;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = CNT_W'(GAP_CLKS - 1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP, S_REST: begin
            if (cnt_q == '0) step_end = 1'b1;
            else             cnt_d    = cnt_q - CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // The following entry is fetched on the last cycle of a step so the
      // next step begins with no dead cycle in between.
      if (step_end) begin
         if (!last_step) begin
            load    = 1'b1;
            rd_addr = step_q + AW'(1);
            step_d  = step_q + AW'(1);
         end else if (loop_en) begin
            load   = 1'b1;
            step_d = '0;
         end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            step_d  = '0;
            note_d  = '0;
            oct_d   = '0;
            cnt_d   = '0;
         end
      end

      if (load) begin
         if (rd_note >= NUM_SEMITONES) begin
            state_d = S_REST;
            note_d  = '0;
            oct_d   = '0;
            cnt_d   = step_len - CNT_W'(1);
         end else begin
            state_d = S_SOUND;
            note_d  = rd_note;
            oct_d   = rd_oct;
            cnt_d   = step_len - CNT_W'(GAP_CLKS) - CNT_W'(1);
         end
      end

      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         step_d  = '0;
         note_d  = '0;
         oct_d   = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         note_q  <= '0;
         oct_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         done_q  <= done_d;
      end
   end

   assign key_press = (state_q == S_SOUND);
   assign note_idx  = note_q;
   assign octave    = oct_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign cur_step  = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with CLK_PER_BEAT=10, GAP_CLKS=2, DEPTH=16.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [10:0] wr_data = '0;
   logic [4:0]  seq_len = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic        key_press;
   logic [3:0]  note_idx;
   logic [2:0]  octave;
   logic        busy;
   logic        done;
   logic [3:0]  cur_step;
   logic [13:0] obs;

   int total = 0;
   int bad   = 0;

   note_sequencer #(.CLK_PER_BEAT(10), .GAP_CLKS(2), .DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .seq_len   (seq_len),
      .start     (start),
      .stop      (stop),
      .loop_en   (loop_en),
      .key_press (key_press),
      .note_idx  (note_idx),
      .octave    (octave),
      .busy      (busy),
      .done      (done),
      .cur_step  (cur_step)
   );

   always #5 clk = ~clk;

   // {busy, done, key_press, note_idx, octave, cur_step}
   assign obs = {busy, done, key_press, note_idx, octave, cur_step};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [10:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic load_basic();
      wr(4'd0, {4'd9, 3'd4, 4'd2});
      wr(4'd1, {4'd15, 3'd0, 4'd1});
      wr(4'd2, {4'd0, 3'd5, 4'd1});
   endtask

   // Hand timeline of the three-entry melody started in cycle 0.
   function automatic logic [13:0] basic_exp(int c);
      logic       b, d, k;
      logic [3:0] n, s;
      logic [2:0] o;
      b = 1'b0; d = 1'b0; k = 1'b0; n = 4'd0; o = 3'd0; s = 4'd0;
      if (c >= 1 && c <= 20) begin
         b = 1'b1; n = 4'd9; o = 3'd4; k = (c <= 18);
      end else if (c >= 21 && c <= 30) begin
         b = 1'b1; s = 4'd1;
      end else if (c >= 31 && c <= 40) begin
         b = 1'b1; o = 3'd5; s = 4'd2; k = (c <= 38);
      end else if (c == 41) begin
         d = 1'b1;
      end
      return {b, d, k, n, o, s};
   endfunction

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++;
      if (obs !== 14'd0) begin
         bad++;
         $display("FAIL reset_state got=%h exp=%h", obs, 14'd0);
      end
      reset = 1'b0;
      tick();
      total++;
      if (obs !== 14'd0) begin
         bad++;
         $display("FAIL reset_release got=%h exp=%h", obs, 14'd0);
      end
   endtask

   task automatic test_basic();
      load_basic();
      seq_len = 5'd3;
      loop_en = 1'b0;
      go();
      for (int c = 1; c <= 45; c++) begin
         total++;
         if (obs !== basic_exp(c)) begin
            bad++;
            $display("FAIL basic c=%0d got=%h exp=%h", c, obs, basic_exp(c));
         end
         tick();
      end
   endtask

   task automatic test_loop();
      logic [13:0] e;
      load_basic();
      seq_len = 5'd3;
      loop_en = 1'b1;
      go();
      for (int c = 1; c <= 84; c++) begin
         if (c == 50) loop_en = 1'b0;
         e = (c <= 40) ? basic_exp(c) : basic_exp(c - 40);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL loop c=%0d got=%h exp=%h", c, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_stop();
      logic [13:0] e;
      load_basic();
      seq_len = 5'd3;
      loop_en = 1'b0;
      go();
      for (int c = 1; c <= 45; c++) begin
         if (c == 5) begin
            stop  = 1'b1;
            start = 1'b1;
         end else begin
            stop  = 1'b0;
            start = 1'b0;
         end
         e = (c <= 5) ? basic_exp(c) : 14'd0;
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL stop c=%0d got=%h exp=%h", c, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_edge();
      logic [13:0] e;
      logic [3:0]  s;
      // zero duration plays as one beat
      wr(4'd0, {4'd2, 3'd3, 4'd0});
      seq_len = 5'd1;
      loop_en = 1'b0;
      go();
      for (int c = 1; c <= 12; c++) begin
         e = 14'd0;
         if (c <= 10) e = {1'b1, 1'b0, (c <= 8), 4'd2, 3'd3, 4'd0};
         else if (c == 11) e = {1'b0, 1'b1, 12'd0};
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL dur0 c=%0d got=%h exp=%h", c, obs, e);
         end
         tick();
      end
      // invalid note behaves as a rest
      wr(4'd0, {4'd13, 3'd6, 4'd1});
      go();
      for (int c = 1; c <= 12; c++) begin
         e = 14'd0;
         if (c <= 10) e = {1'b1, 13'd0};
         else if (c == 11) e = {1'b0, 1'b1, 12'd0};
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL note13 c=%0d got=%h exp=%h", c, obs, e);
         end
         tick();
      end
      // zero length start is ignored
      seq_len = 5'd0;
      go();
      for (int c = 1; c <= 5; c++) begin
         total++;
         if (obs !== 14'd0) begin
            bad++;
            $display("FAIL len0 c=%0d got=%h exp=%h", c, obs, 14'd0);
         end
         tick();
      end
      // oversize length clamps to 16 steps
      for (int i = 0; i < 16; i++) wr(4'(i), {4'(i % 12), 3'd1, 4'd1});
      seq_len = 5'd20;
      go();
      for (int c = 1; c <= 163; c++) begin
         e = 14'd0;
         if (c <= 160) begin
            s = 4'((c - 1) / 10);
            e = {1'b1, 1'b0, (((c - 1) % 10) < 8), 4'(s % 12), 3'd1, s};
         end else if (c == 161) begin
            e = {1'b0, 1'b1, 12'd0};
         end
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL len20 c=%0d got=%h exp=%h", c, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_write_during_play();
      logic [13:0] e;
      load_basic();
      seq_len = 5'd3;
      loop_en = 1'b1;
      go();
      for (int c = 1; c <= 74; c++) begin
         if (c == 25) begin
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_data = {4'd4, 3'd3, 4'd1};
         end else begin
            wr_en = 1'b0;
         end
         if (c == 55) loop_en = 1'b0;
         if (c <= 40)      e = basic_exp(c);
         else if (c <= 50) e = {1'b1, 1'b0, (c <= 48), 4'd4, 3'd3, 4'd0};
         else              e = basic_exp(c - 30);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL wr_play c=%0d got=%h exp=%h", c, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      load_basic();
      seq_len = 5'd3;
      loop_en = 1'b0;
      go();
      for (int c = 1; c <= 8; c++) begin
         reset = (c == 5);
         total++;
         if (c <= 5 && obs !== basic_exp(c)) begin
            bad++;
            $display("FAIL rst_mid_pre c=%0d got=%h exp=%h", c, obs, basic_exp(c));
         end else if (c > 5 && obs !== 14'd0) begin
            bad++;
            $display("FAIL rst_mid_post c=%0d got=%h exp=%h", c, obs, 14'd0);
         end
         tick();
      end
      reset = 1'b0;
      go();
      for (int c = 1; c <= 43; c++) begin
         total++;
         if (obs !== basic_exp(c)) begin
            bad++;
            $display("FAIL rst_replay c=%0d got=%h exp=%h", c, obs, basic_exp(c));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loop();
      test_stop();
      test_edge();
      test_write_during_play();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
